// File: rtl/registrador_rolagem.sv
// registrador_rolagem: column register for the scrolling LED panel.
// Holds the panel pattern, loads it from the column multiplexer (mode 00), and
// rotates it left (mode 01) or right (mode 10) once every DIV enabled cycles.
// Mode 11 holds the pattern; with the macro PISCA_EN defined, mode 11 blinks
// the display instead (pattern kept internally, output blanked on alternate
// prescaler periods).
//
// Output timing: saida/posicao are registered (1-cycle latency). passo is a
// registered pulse, high exactly in the cycle following each shift edge; it
// carries no handshake and is never back-pressured.
module registrador_rolagem #(
  parameter int LARGURA = 8,
  parameter int DIV     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ch0,
  input  logic                       ch1,
  input  logic [LARGURA-1:0]         dado_entrada,
  input  logic                       habilita,
  output logic [LARGURA-1:0]         saida,
  output logic                       passo,
  output logic [$clog2(LARGURA)-1:0] posicao
);

  localparam int PW = $clog2(LARGURA);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    PARA_EXIBICAO = 2'b00,
    DIR_ESQ       = 2'b01,
    ESQ_DIR       = 2'b10,
    SEGURA        = 2'b11
  } modo_t;

  modo_t               modo;
  modo_t               modo_reg;
  logic                mudou;
  logic                conta_ativa;
  logic                tick;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [LARGURA-1:0]  padrao;
  logic [LARGURA-1:0]  padrao_nxt;
  logic [PW-1:0]       pos_nxt;
  logic                passo_nxt;

  assign modo  = modo_t'({ch1, ch0});
  // A mode change restarts the prescaler and suppresses the tick of that cycle.
  assign mudou = (modo != modo_reg);

  // Prescaler runs only in the modes that consume ticks.
  always_comb begin
    conta_ativa = (modo == DIR_ESQ) || (modo == ESQ_DIR);
`ifdef PISCA_EN
    if (modo == SEGURA) conta_ativa = 1'b1;
`endif
  end

  assign tick = conta_ativa && !mudou && habilita && (cnt == CW'(DIV - 1));

  // Prescaler next count: cleared when idle or on a mode change, frozen while habilita=0.
  always_comb begin
    cnt_nxt = cnt;
    if (!conta_ativa || mudou) begin
      cnt_nxt = '0;
    end else if (habilita) begin
      cnt_nxt = tick ? '0 : cnt + CW'(1);
    end
  end

  // Pattern, position and step pulse next values per mode.
  always_comb begin
    padrao_nxt = padrao;
    pos_nxt    = posicao;
    passo_nxt  = 1'b0;
    case (modo)
      PARA_EXIBICAO: begin
        padrao_nxt = dado_entrada;
        pos_nxt    = '0;
      end
      DIR_ESQ: begin
        passo_nxt = tick;
        if (tick) begin
          padrao_nxt = {padrao[LARGURA-2:0], padrao[LARGURA-1]};
          pos_nxt    = posicao + PW'(1);
        end
      end
      ESQ_DIR: begin
        passo_nxt = tick;
        if (tick) begin
          padrao_nxt = {padrao[0], padrao[LARGURA-1:1]};
          pos_nxt    = posicao - PW'(1);
        end
      end
      default: begin
        padrao_nxt = padrao;
        pos_nxt    = posicao;
      end
    endcase
  end

  // State register: mode tracking, prescaler, pattern, position, step pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      modo_reg <= PARA_EXIBICAO;
      cnt      <= '0;
      padrao   <= '0;
      posicao  <= '0;
      passo    <= 1'b0;
    end else begin
      modo_reg <= modo;
      cnt      <= cnt_nxt;
      padrao   <= padrao_nxt;
      posicao  <= pos_nxt;
      passo    <= passo_nxt;
    end
  end

`ifdef PISCA_EN
  logic apagado;
  logic apagado_nxt;

  // Blink phase toggles on each tick while staying in mode 11; cleared otherwise.
  always_comb begin
    apagado_nxt = 1'b0;
    if (modo == SEGURA && !mudou) apagado_nxt = apagado ^ tick;
  end

  // Blink phase register.
  always_ff @(posedge clock) begin
    if (reset) apagado <= 1'b0;
    else       apagado <= apagado_nxt;
  end

  // Blanked phase shows dark columns; the stored pattern is untouched.
  always_comb begin
    saida = apagado ? '0 : padrao;
  end
`else
  // Display shows the stored pattern directly.
  always_comb begin
    saida = padrao;
  end
`endif

endmodule

// File: tb/tb_registrador_rolagem.sv
// tb_registrador_rolagem: directed plan plus randomized traffic, checked by a
// scoreboard fed from a behavioural model (pattern + integer offset + count of
// enabled cycles since the last step).
module tb_registrador_rolagem;

  localparam int L   = 8;
  localparam int DIV = 4;
  localparam int PW  = 3;
  localparam int W   = L + 1 + PW;
`ifdef PISCA_EN
  localparam bit PISCA = 1'b1;
`else
  localparam bit PISCA = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          ch0;
  logic          ch1;
  logic          habilita;
  logic [L-1:0]  dado_entrada;
  logic [L-1:0]  saida;
  logic          passo;
  logic [PW-1:0] posicao;

  registrador_rolagem #(.LARGURA(L), .DIV(DIV)) dut (
    .clock(clock),
    .reset(reset),
    .ch0(ch0),
    .ch1(ch1),
    .dado_entrada(dado_entrada),
    .habilita(habilita),
    .saida(saida),
    .passo(passo),
    .posicao(posicao)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  // reference model state
  logic [L-1:0] m_pat   = '0;
  int           m_pos   = 0;
  int           m_en    = 0;
  logic [1:0]   m_prev  = 2'b00;
  bit           m_blank = 1'b0;
  bit           m_passo = 1'b0;

  // rotate by k places: bit i moves to bit (i+k) mod L
  function automatic logic [L-1:0] rot(input logic [L-1:0] v, input int k);
    logic [L-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) r[(i + k + L) % L] = v[i];
    return r;
  endfunction

  task automatic model_step(input logic r, input logic [1:0] m,
                            input logic [L-1:0] d, input logic h);
    bit changed;
    bit run;
    bit tk;
    logic [L-1:0] shown;
    tk = 1'b0;
    if (r) begin
      m_pat = '0; m_pos = 0; m_en = 0; m_prev = 2'b00; m_blank = 1'b0; m_passo = 1'b0;
    end else begin
      changed = (m != m_prev);
      m_prev  = m;
      run = (m == 2'b01) || (m == 2'b10) || (PISCA && m == 2'b11);
      if (changed || !run) begin
        m_en = 0;
      end else if (h) begin
        m_en++;
        if (m_en == DIV) begin
          tk = 1'b1;
          m_en = 0;
        end
      end
      case (m)
        2'b00: begin m_pat = d; m_pos = 0; m_blank = 1'b0; end
        2'b01: begin
          if (tk) begin m_pat = rot(m_pat, 1); m_pos = (m_pos + 1) % L; end
          m_blank = 1'b0;
        end
        2'b10: begin
          if (tk) begin m_pat = rot(m_pat, -1); m_pos = (m_pos + L - 1) % L; end
          m_blank = 1'b0;
        end
        default: begin
          if (changed) m_blank = 1'b0;
          else if (tk) m_blank = !m_blank;
        end
      endcase
      m_passo = tk && (m == 2'b01 || m == 2'b10);
    end
    shown = m_blank ? {L{1'b0}} : m_pat;
    exp_q.push_back({shown, m_passo, PW'(m_pos)});
  endtask

  // driver: apply one cycle of inputs, record expectation, let the edge pass
  task automatic cyc(input logic r, input logic [1:0] m, input logic [L-1:0] d, input logic h);
    reset = r; {ch1, ch0} = m; dado_entrada = d; habilita = h;
    model_step(r, m, d, h);
    @(posedge clock);
    #2;
  endtask

  // directed absolute check against hand-derived values
  task automatic chk(input string nm, input logic [L-1:0] s, input logic p, input logic [PW-1:0] q);
    total++;
    if (saida !== s || passo !== p || posicao !== q) begin
      bad++;
      $display("FAIL %s: got saida=%h passo=%b posicao=%0d, want saida=%h passo=%b posicao=%0d",
               nm, saida, passo, posicao, s, p, q);
    end
  endtask

  // scoreboard monitor: one expectation per clock edge
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      total++;
      if ({saida, passo, posicao} !== exp_w) begin
        bad++;
        $display("FAIL scoreboard t=%0t: got saida=%h passo=%b posicao=%0d, want saida=%h passo=%b posicao=%0d",
                 $time, saida, passo, posicao, exp_w[W-1 -: L], exp_w[PW], exp_w[PW-1:0]);
      end
    end
  end

  initial begin
    logic [L-1:0] want;
    int m;
    int left;
    reset = 1'b1; ch0 = 1'b0; ch1 = 1'b0; dado_entrada = '0; habilita = 1'b0;
    @(negedge clock);

    cyc(1, 2'b00, 8'h00, 0); cyc(1, 2'b00, 8'h00, 0);
    chk("reset", 8'h00, 0, 0);

    cyc(0, 2'b00, 8'hA5, 1);
    chk("load", 8'hA5, 0, 0);

    // right-to-left: change cycle + DIV enabled cycles per step
    repeat (5) cyc(0, 2'b01, 8'hA5, 1);
    chk("rl_step1", 8'h4B, 1, 1);
    repeat (4) cyc(0, 2'b01, 8'hA5, 1);
    chk("rl_step2", 8'h96, 1, 2);

    cyc(0, 2'b00, 8'hA5, 1);
    chk("reload", 8'hA5, 0, 0);
    repeat (5) cyc(0, 2'b10, 8'hA5, 1);
    chk("lr_step1", 8'hD2, 1, 7);
    repeat (4) cyc(0, 2'b10, 8'hA5, 1);
    chk("lr_step2", 8'h69, 1, 6);

    // stall mid-count
    cyc(0, 2'b00, 8'hA5, 1);
    cyc(0, 2'b01, 8'hA5, 1);
    repeat (2) cyc(0, 2'b01, 8'hA5, 1);
    repeat (3) cyc(0, 2'b01, 8'hA5, 0);
    cyc(0, 2'b01, 8'hA5, 1);
    chk("stall_wait", 8'hA5, 0, 0);
    cyc(0, 2'b01, 8'hA5, 1);
    chk("stall_step", 8'h4B, 1, 1);

    // remaining 7 steps complete a full rotation
    repeat (28) cyc(0, 2'b01, 8'hA5, 1);
    chk("full_cycle", 8'hA5, 1, 0);
    repeat (3) cyc(0, 2'b01, 8'hA5, 1);
    chk("pre_tick", 8'hA5, 0, 0);
    cyc(1, 2'b01, 8'hA5, 1);
    chk("reset_on_tick", 8'h00, 0, 0);

    // hold / blink
    cyc(0, 2'b00, 8'h3C, 1);
    chk("load_3c", 8'h3C, 0, 0);
    for (int j = 1; j <= 20; j++) begin
      cyc(0, 2'b11, 8'h00, 1);
`ifdef PISCA_EN
      want = (((j - 1) / 4) % 2 == 1) ? 8'h00 : 8'h3C;
      chk("blink", want, 0, 0);
`else
      want = 8'h3C;
      chk("hold", want, 0, 0);
`endif
    end
    cyc(0, 2'b00, 8'h3C, 1);
    chk("restore", 8'h3C, 0, 0);

    // randomized traffic with sticky modes
    m = 0;
    left = 0;
    repeat (400) begin
      if (left == 0) begin
        m = int'($urandom_range(0, 3));
        left = int'($urandom_range(1, 14));
      end
      left--;
      cyc($urandom_range(0, 80) == 0, m[1:0], L'($urandom), $urandom_range(0, 3) != 0);
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/registrador_rolagem.md
Name: registrador_rolagem

Overview:
- Column register that stores the panel pattern and drives the display. It is the flip-flop stage directly downstream of the per-column input multiplexer.
- Takes the same ch1/ch0 mode selects as the multiplexer: load, shift right-to-left, shift left-to-right, hold.
- Adds the sequential parts: a scroll-speed prescaler, mode-change synchronisation, rotation with wrap-around, and a scroll position counter.
- Output feeds the LED column drivers.

Parameters:
- LARGURA, 8, number of panel columns; power of two, at least 2.
- DIV, 4, clock cycles per scroll step while habilita=1; at least 1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ch0  in  1  mode select LSB.
- ch1  in  1  mode select MSB.
- dado_entrada  in  LARGURA  pattern loaded in mode 00.
- habilita  in  1  prescaler enable; scrolling freezes while low.
- saida  out  LARGURA  displayed columns; bit 0 = rightmost column.
- passo  out  1  one-cycle pulse, high the cycle after each shift.
- posicao  out  $clog2(LARGURA)  scroll offset, modulo LARGURA.

Behaviour:
- One clock; reset is synchronous and active-high. reset dominates every other input.
- On reset:
  - saida=0, posicao=0, passo=0
  - prescaler cnt=0
  - modo_reg=2'b00
- Mode tracking: each cycle modo_reg <= {ch1,ch0}.
- Mode change: if {ch1,ch0} != modo_reg, then cnt <= 0 and no tick occurs that cycle. The first shift in the new mode comes DIV enabled cycles later.
- Prescaler:
  - Active only in modes 01 and 10, and only when habilita=1.
  - tick = (cnt==DIV-1) && habilita.
  - On tick, cnt <= 0; otherwise cnt <= cnt+1 while habilita=1.
  - cnt holds its value while habilita=0.
  - In modes 00 and 11, cnt is held at 0.
- Mode 00 (para_exibicao): saida <= dado_entrada every cycle, regardless of habilita. Latency 1 cycle. posicao <= 0, passo=0.
- Mode 01 (dir_esq), on tick:
  - Content moves toward the MSB (rotate left): saida <= {saida[LARGURA-2:0], saida[LARGURA-1]}.
  - posicao <= posicao+1, wrapping LARGURA-1 -> 0.
- Mode 10 (esq_dir), on tick:
  - Rotate right: saida <= {saida[0], saida[LARGURA-1:1]}.
  - posicao <= posicao-1, wrapping 0 -> LARGURA-1.
- Mode 11: hold saida and posicao (see Optional Feature).
- passo:
  - Registered; passo <= tick in modes 01/10, otherwise 0.
  - Never high for two consecutive cycles when DIV>1. With DIV=1 it is continuously high while shifting.
- Rotation is lossless: after LARGURA shifts in one direction, saida equals its value before the first of those shifts, and posicao has returned to its start value.
- Reset mid-count: the count is discarded. After reset, the block waits in mode 00 semantics until modo_reg is updated.

Optional Feature:
- Macro: PISCA_EN.
- Defined: mode 11 blinks.
  - The prescaler runs in mode 11 under the same habilita and tick rules.
  - An internal bit apagado toggles on each tick.
  - While apagado=1, saida presents 0. The stored pattern is kept internally and reappears when apagado returns to 0.
  - apagado is cleared on reset, on entry to any other mode, and on entry to mode 11.
  - posicao is unchanged in mode 11; passo stays 0.
- Undefined: mode 11 is a plain hold. No apagado logic is synthesised.

Test Plan (LARGURA=8, DIV=4):
- Load: reset, then mode 00 with dado_entrada=8'hA5 -> saida=8'hA5 one cycle later, posicao=0, passo=0.
- Scroll right-to-left: from 8'hA5, mode 01, habilita=1 -> saida=8'h4B after 4 cycles, then 8'h96 after 8. passo pulses once per step. posicao=1, then 2.
- Scroll left-to-right: from 8'hA5, mode 10 -> first step gives 8'hD2 with posicao=7 (wrap), then 8'h69 with posicao=6.
- Stall: mode 01 with habilita dropped low for 3 cycles mid-count -> the step arrives 3 cycles late. saida and posicao are otherwise correct.
- Full cycle and reset: 8 steps in mode 01 -> saida=8'hA5, posicao=0. Asserting reset on a tick cycle -> next edge gives saida=0, posicao=0, passo=0.
- Hold and blink: mode 11 from 8'h3C.
  - Without PISCA_EN, saida stays 8'h3C for 20 cycles.
  - With PISCA_EN, saida alternates 8'h00 and 8'h3C every 4 cycles.
  - Switching to mode 00 restores loaded data next cycle.
